// File: rtl/frame_field_sequencer.sv
// CAN 2.0A frame field sequencer: tracks which field the next sampled bit belongs to,
// captures RTR/DLC, and recovers to bus idle after errors or an interframe overload.
module frame_field_sequencer (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       Stuff_Skip,
    input  logic       Frame_Error,
    output logic       ARB_Flag,
    output logic       CTRL_Flag,
    output logic       DATA_Flag,
    output logic       CRC_Flag,
    output logic       CRC_Del_Flag,
    output logic       ACK_Flag,
    output logic       ACK_Del_Flag,
    output logic       EOF_Flag,
    output logic       IFS_Flag,
    output logic       Frame_Done,
    output logic       Bus_Idle,
    output logic [3:0] DLC,
    output logic       RTR
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL,
        S_ACK, S_ACK_DEL, S_EOF, S_IFS, S_WAIT_IDLE
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] cnt, cnt_nxt;
    logic [6:0] field_len;
    logic [3:0] dlc_nxt, dlc_shift;
    logic       rtr_nxt, done_nxt;
    logic       stuffable, counted, last_bit;
    logic [8:0] flag_n, flag_n_nxt;

    assign {IFS_Flag, EOF_Flag, ACK_Del_Flag, ACK_Flag, CRC_Del_Flag,
            CRC_Flag, DATA_Flag, CTRL_Flag, ARB_Flag} = flag_n;

    // DLC values above 8 still carry 8 data bytes.
    always_comb begin
        case (state)
            S_ARB:   field_len = 7'd12;
            S_CTRL:  field_len = 7'd6;
            S_DATA:  field_len = DLC[3] ? 7'd64 : {1'b0, DLC[2:0], 3'b000};
            S_CRC:   field_len = 7'd15;
            S_EOF:   field_len = 7'd7;
            S_IFS:   field_len = 7'd3;
            default: field_len = 7'd1;
        endcase
    end

    assign stuffable = (state == S_ARB) || (state == S_CTRL) ||
                       (state == S_DATA) || (state == S_CRC);
    assign counted   = !(stuffable && Stuff_Skip);
    assign last_bit  = (cnt == field_len - 7'd1);
    assign dlc_shift = {DLC[2:0], RX};

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dlc_nxt   = DLC;
        rtr_nxt   = RTR;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!RX) state_nxt = S_ARB;
            end
            S_WAIT_IDLE: begin
                if (!RX)                 cnt_nxt   = 7'd0;
                else if (cnt == 7'd10)   state_nxt = S_IDLE;
                else                     cnt_nxt   = cnt + 7'd1;
            end
            S_IFS: begin
                // A dominant third IFS bit is the next frame's SOF.
                if (cnt == 7'd2)  state_nxt = RX ? S_IDLE : S_ARB;
                else if (!RX)     state_nxt = S_WAIT_IDLE;
                else              cnt_nxt   = cnt + 7'd1;
            end
            default: begin
                if (counted) begin
                    if (state == S_ARB && cnt == 7'd11) rtr_nxt = RX;
                    if (state == S_CTRL && cnt >= 7'd2) dlc_nxt = dlc_shift;
                    if (last_bit) begin
                        case (state)
                            S_ARB:     state_nxt = S_CTRL;
                            S_CTRL:    state_nxt = (!RTR && dlc_shift != 4'd0) ? S_DATA : S_CRC;
                            S_DATA:    state_nxt = S_CRC;
                            S_CRC:     state_nxt = S_CRC_DEL;
                            S_CRC_DEL: state_nxt = S_ACK;
                            S_ACK:     state_nxt = S_ACK_DEL;
                            S_ACK_DEL: state_nxt = S_EOF;
                            default: begin
                                state_nxt = S_IFS;
                                done_nxt  = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
        endcase

        // A reported error overrides stuffing and every field transition.
        if (!Frame_Error && state != S_IDLE && state != S_WAIT_IDLE) begin
            state_nxt = S_WAIT_IDLE;
            dlc_nxt   = DLC;
            rtr_nxt   = RTR;
            done_nxt  = 1'b0;
        end

        if (state_nxt != state) cnt_nxt = 7'd0;
    end

    always_comb begin
        flag_n_nxt = 9'h1FF;
        case (state_nxt)
            S_ARB:     flag_n_nxt[0] = 1'b0;
            S_CTRL:    flag_n_nxt[1] = 1'b0;
            S_DATA:    flag_n_nxt[2] = 1'b0;
            S_CRC:     flag_n_nxt[3] = 1'b0;
            S_CRC_DEL: flag_n_nxt[4] = 1'b0;
            S_ACK:     flag_n_nxt[5] = 1'b0;
            S_ACK_DEL: flag_n_nxt[6] = 1'b0;
            S_EOF:     flag_n_nxt[7] = 1'b0;
            S_IFS:     flag_n_nxt[8] = 1'b0;
            default:   flag_n_nxt    = 9'h1FF;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge SP) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 7'd0;
            DLC        <= 4'd0;
            RTR        <= 1'b0;
            Frame_Done <= 1'b0;
            Bus_Idle   <= 1'b1;
            flag_n     <= 9'h1FF;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            DLC        <= dlc_nxt;
            RTR        <= rtr_nxt;
            Frame_Done <= done_nxt;
            Bus_Idle   <= (state_nxt == S_IDLE);
            flag_n     <= flag_n_nxt;
        end
    end

endmodule

// File: tb/tb_frame_field_sequencer.sv
// Scoreboard bench for frame_field_sequencer: each driven sample pushes the outputs
// expected while it is sampled; a negedge monitor pops and compares them.
module tb_frame_field_sequencer;

    logic       SP = 1'b0;
    logic       reset, RX, Stuff_Skip, Frame_Error;
    logic       ARB_Flag, CTRL_Flag, DATA_Flag, CRC_Flag, CRC_Del_Flag;
    logic       ACK_Flag, ACK_Del_Flag, EOF_Flag, IFS_Flag;
    logic       Frame_Done, Bus_Idle, RTR;
    logic [3:0] DLC;

    typedef enum int {F_ARB = 0, F_CTRL, F_DATA, F_CRC, F_CRC_DEL, F_ACK,
                      F_ACK_DEL, F_EOF, F_IFS, F_NONE} fld_t;

    typedef struct {
        int   cyc;
        fld_t fld;
        bit   idle;
        bit   done;
        int   edlc;
        int   ertr;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    frame_field_sequencer dut (
        .SP(SP), .reset(reset), .RX(RX), .Stuff_Skip(Stuff_Skip), .Frame_Error(Frame_Error),
        .ARB_Flag(ARB_Flag), .CTRL_Flag(CTRL_Flag), .DATA_Flag(DATA_Flag), .CRC_Flag(CRC_Flag),
        .CRC_Del_Flag(CRC_Del_Flag), .ACK_Flag(ACK_Flag), .ACK_Del_Flag(ACK_Del_Flag),
        .EOF_Flag(EOF_Flag), .IFS_Flag(IFS_Flag), .Frame_Done(Frame_Done),
        .Bus_Idle(Bus_Idle), .DLC(DLC), .RTR(RTR)
    );

    always #5 SP = ~SP;
    always @(posedge SP) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: outputs visible while a sample is pending must match its expectation.
    always @(negedge SP) begin
        if (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            exp_t e;
            logic [8:0] exp_flags, act_flags;
            e = q.pop_front();
            check("expectation_on_time", e.cyc, edge_cnt);
            exp_flags = 9'h1FF;
            if (e.fld != F_NONE) exp_flags[int'(e.fld)] = 1'b0;
            act_flags = {IFS_Flag, EOF_Flag, ACK_Del_Flag, ACK_Flag, CRC_Del_Flag,
                         CRC_Flag, DATA_Flag, CTRL_Flag, ARB_Flag};
            check("flags", int'(act_flags), int'(exp_flags));
            check("bus_idle", int'(Bus_Idle), int'(e.idle));
            check("frame_done", int'(Frame_Done), int'(e.done));
            if (e.edlc >= 0) check("dlc", int'(DLC), e.edlc);
            if (e.ertr >= 0) check("rtr", int'(RTR), e.ertr);
        end
    end

    // Drive one sample and record what the DUT must present while it is sampled.
    task automatic sample(input logic rx, input logic skip, input logic err,
                          input fld_t fld, input bit idle, input bit done,
                          input int edlc = -1, input int ertr = -1);
        exp_t e;
        RX          = rx;
        Stuff_Skip  = skip;
        Frame_Error = err;
        e.cyc  = edge_cnt;
        e.fld  = fld;
        e.idle = idle;
        e.done = done;
        e.edlc = edlc;
        e.ertr = ertr;
        q.push_back(e);
        @(posedge SP);
        #1;
    endtask

    // Everything after SOF up to the last EOF bit; optional stuff/skip insertion and aborts.
    task automatic frame_body(input bit rtr, input logic [3:0] dlc,
                              input int arb_stuff = -1, input int crc_stuff = -1,
                              input int eof_skip = -1, input int abort_at = -1,
                              input bit abort_by_reset = 1'b0);
        logic [5:0] ctrl;
        int n;
        ctrl = {2'b00, dlc};
        n = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 12; i++) begin
            if (i == arb_stuff) sample(1'b1, 1'b1, 1'b1, F_ARB, 0, 0);
            sample((i == 11) ? rtr : 1'b0, 1'b0, 1'b1, F_ARB, 0, 0);
        end
        for (int i = 0; i < 6; i++) sample(ctrl[5-i], 1'b0, 1'b1, F_CTRL, 0, 0);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                if (abort_by_reset) begin
                    reset = 1'b0;
                    sample(1'b1, 1'b0, 1'b1, F_DATA, 0, 0);
                    reset = 1'b1;
                end else begin
                    sample(1'b0, 1'b1, 1'b0, F_DATA, 0, 0);
                end
                return;
            end
            sample(logic'(i % 2), 1'b0, 1'b1, F_DATA, 0, 0,
                   (i == 0) ? int'(dlc) : -1, (i == 0) ? int'(rtr) : -1);
        end
        for (int i = 0; i < 15; i++) begin
            if (i == crc_stuff) sample(1'b1, 1'b1, 1'b1, F_CRC, 0, 0);
            sample(1'b0, 1'b0, 1'b1, F_CRC, 0, 0,
                   (i == 0 && n == 0) ? int'(dlc) : -1, (i == 0 && n == 0) ? int'(rtr) : -1);
        end
        sample(1'b1, 1'b0, 1'b1, F_CRC_DEL, 0, 0);
        sample(1'b0, 1'b0, 1'b1, F_ACK, 0, 0);
        sample(1'b1, 1'b0, 1'b1, F_ACK_DEL, 0, 0);
        for (int i = 0; i < 7; i++) sample(1'b1, (i == eof_skip), 1'b1, F_EOF, 0, 0);
    endtask

    // IFS bits; a dominant bit at zero_at (1..3) ends the IFS early or starts a frame.
    task automatic ifs(input int zero_at);
        for (int b = 1; b <= 3; b++) begin
            sample((b == zero_at) ? 1'b0 : 1'b1, 1'b0, 1'b1, F_IFS, 0, (b == 1));
            if (b == zero_at) return;
        end
    endtask

    task automatic recessive_wait(input int n);
        for (int i = 0; i < n; i++) sample(1'b1, 1'b0, 1'b1, F_NONE, 0, 0);
    endtask

    task automatic sof();
        sample(1'b0, 1'b0, 1'b1, F_NONE, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; RX = 1'b1; Stuff_Skip = 1'b0; Frame_Error = 1'b1;
        repeat (3) @(posedge SP);
        #1;
        reset = 1'b1;

        // Reset state, idle while recessive (a dominant-error input is ignored in idle).
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0, 0, 0);
        sample(1'b1, 1'b0, 1'b0, F_NONE, 1, 0);

        // Data frame DLC=2: 12/6/16/15/1/1/1/7 then 3 IFS bits back to idle.
        sof();
        frame_body(1'b0, 4'd2);
        ifs(0);
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0, 2, 0);

        // Remote frame with DLC=5 skips DATA; then DLC=15 carries 64 data bits.
        sof();
        frame_body(1'b1, 4'd5);
        ifs(0);
        sof();
        frame_body(1'b0, 4'd15);
        ifs(0);
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0, 15, 0);

        // Stuff bits lengthen ARB and CRC; a skip flag in EOF is ignored.
        sof();
        frame_body(1'b0, 4'd2, 4, 5, 2);
        ifs(0);

        // Dominant IFS bit 2 -> wait for 11 recessive bits.
        sof();
        frame_body(1'b0, 4'd1);
        ifs(2);
        recessive_wait(11);

        // Dominant IFS bit 3 is SOF of the next frame, no idle cycle in between.
        sof();
        frame_body(1'b0, 4'd1);
        ifs(3);
        frame_body(1'b0, 4'd0);
        ifs(0);

        // Error at DATA bit 3 with stuff flag: WAIT_IDLE, 5 ones, 1 zero, 11 ones.
        sof();
        frame_body(1'b0, 4'd2, -1, -1, -1, 2, 1'b0);
        recessive_wait(5);
        sample(1'b0, 1'b0, 1'b1, F_NONE, 0, 0);
        recessive_wait(11);
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0);

        // Reset mid-DATA clears everything; a new frame then runs normally.
        sof();
        frame_body(1'b0, 4'd4, -1, -1, -1, 5, 1'b1);
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0, 0, 0);
        sof();
        frame_body(1'b0, 4'd3);
        ifs(0);
        sample(1'b1, 1'b0, 1'b1, F_NONE, 1, 0, 3, 0);

        repeat (2) @(posedge SP);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
